phase_sel_decim: RTL and testbench
==================================

Name: phase_sel_decim

Overview:
- Downstream consumer of the sync detector in the basic BPSK receive chain.
- After o_sync from the sync detector goes high, it measures the energy of each oversampling phase of the raised-cosine filter output over a fixed window and selects the strongest phase.
- It then decimates the filter output at that phase and slices each sample to one bit per symbol, feeding the bit-error checker.

Parameters:
- S_IN, 10, width of the signed filter sample.
- OS, 4, oversampling factor (samples per symbol); power of two, at least 2.
- N_ACQ, 64, symbols accumulated per phase during acquisition; power of two.
- ACC_W, 16, accumulator width; must be at least S_IN+log2(N_ACQ).
- PH_W, 2, phase index width; equals log2(OS).

Ports:
- clock  input  1  system clock.
- i_reset  input  1  asynchronous, active-low reset.
- i_enable  input  1  global enable.
- i_valid  input  1  filter sample valid.
- i_sync  input  1  o_sync from the sync detector; high means signal present.
- i_rc_filter  input  S_IN  signed raised-cosine filter output.
- o_bit  output  1  decided symbol: 1 if sample is at least 0, 0 if sample is negative.
- o_valid  output  1  one-cycle pulse qualifying o_bit.
- o_phase  output  PH_W  selected sampling phase.
- o_locked  output  1  high while in TRACK.

Behaviour:
- Reset (async, i_reset=0): state goes to IDLE. cnt, sym_cnt and all accumulators clear. o_bit=0, o_valid=0, o_phase=0, o_locked=0.
- Strobe: stb = i_enable & i_valid. Nothing advances on cycles without stb, except the DECIDE state.
- Phase counter cnt (PH_W bits): increments on every stb in every state. Wraps from OS-1 to 0.
- Magnitude: |x| is computed as unsigned S_IN bits. The most negative input, -2^(S_IN-1), maps to 2^(S_IN-1) with no saturation needed.
- IDLE:
  - Accumulators hold.
  - On stb with i_sync=1 and cnt==OS-1: clear acc[0..OS-1], clear sym_cnt, go to ACQ. The first accumulated sample is therefore phase 0.
- ACQ:
  - On stb: acc[cnt] += |x|.
  - On stb with cnt==OS-1: sym_cnt increments.
  - When that increment completes symbol N_ACQ (sym_cnt==N_ACQ-1 before the increment), go to DECIDE.
  - Exactly OS*N_ACQ samples are accumulated. There is no overflow, given the ACC_W rule.
- DECIDE (exactly one cycle, independent of stb):
  - Argmax over acc; ties resolve to the lowest index.
  - Register the result into o_phase, set o_locked=1, go to TRACK.
  - A stb during this cycle advances cnt but is not accumulated or sliced.
- TRACK:
  - On stb with cnt==o_phase: o_bit <= ~i_rc_filter[S_IN-1] and o_valid <= 1 on the next edge (1-cycle latency).
  - o_valid is 0 in every other cycle.
  - o_phase stays constant while in TRACK.
- Loss of sync:
  - i_sync=0 in ACQ, DECIDE or TRACK returns the block to IDLE on the next edge, whether or not stb is present. o_locked and o_valid go to 0.
  - o_phase holds its last value. o_bit holds.
- i_enable=0 in any state freezes cnt, sym_cnt and the accumulators, and forces o_valid=0. The state is held, except for the loss-of-sync rule above.
- Simultaneous events: if i_sync falls on the same cycle as the ACQ-to-DECIDE or DECIDE-to-TRACK transition, IDLE wins.
- Reset mid-operation: immediate return to reset values. Re-acquisition requires a fresh i_sync alignment.

Decomposition:
- Shared package holds:
  - State enum: IDLE=2'd0, ACQ=2'd1, DECIDE=2'd2, TRACK=2'd3.
  - A constant function clog2 used for PH_W and for the ACC_W check.
- One natural sub-module, phase_argmax: combinational argmax over OS accumulators of ACC_W bits, lowest index on tie, output PH_W. Instantiated once and used in DECIDE.
- The FSM, counters, accumulators and slicer stay in phase_sel_decim.

Test Plan:
1. Assert reset with random inputs, then release. Required: all outputs 0, state IDLE; no o_valid for 100 strobes while i_sync=0.
2. Defaults, stb every cycle, i_sync=1. Per-symbol samples {10,50,200,60}, sign alternating per symbol. Required: o_locked rises exactly one cycle after strobe 256 of ACQ (acc = {640, 3200, 12800, 3840}), o_phase=2.
3. Continue from scenario 2 with symbol signs +,-,-,+. Required: o_bit = 1,0,0,1, each with an o_valid pulse one cycle after the phase-2 strobe; exactly 1 pulse per 4 strobes.
4. All samples of magnitude 100. Required: o_phase=0 (tie goes to the lowest index). Also drive samples of -512 at phase 3 only. Required: o_phase=3 with acc[3]=32768, no wrap.
5. Drop i_sync in TRACK. Required: o_locked=0 and o_valid=0 next cycle, o_phase held. Drop i_sync mid-ACQ, then reassert. Required: a full 256-sample re-acquisition. Assert reset at ACQ sample 100. Required: immediate reset values.
6. i_valid high only every 3rd cycle, plus random i_enable=0 gaps, pattern as in scenario 2. Required: same o_phase=2 and identical bit sequence; no o_valid while i_enable=0.

Source files
------------

// File: rtl/phase_sel_decim_pkg.sv
// phase_sel_decim_pkg: shared state encoding and constant helpers for the phase selector/decimator
package phase_sel_decim_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    DECIDE = 2'd2,
    TRACK  = 2'd3
  } state_t;

  // ceil(log2(v)); used for parameter derivation and width checks at elaboration
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/phase_argmax.sv
// phase_argmax: combinational index of the largest of OS unsigned accumulators, lowest index wins ties
//   acc : OS packed accumulators of ACC_W bits, acc[0] is phase 0
//   idx : index of the strongest phase
module phase_argmax import phase_sel_decim_pkg::*; #(
  parameter int OS    = 4,
  parameter int ACC_W = 16,
  parameter int PH_W  = clog2(OS)
) (
  input  logic [OS-1:0][ACC_W-1:0] acc,
  output logic [PH_W-1:0]          idx
);

  logic [ACC_W-1:0] best;

  // strict greater-than keeps the earlier index on equal energy
  always_comb begin
    idx  = '0;
    best = acc[0];
    for (int i = 1; i < OS; i++)
      if (acc[i] > best) begin
        best = acc[i];
        idx  = PH_W'(i);
      end
  end

endmodule

// File: rtl/phase_sel_decim.sv
// phase_sel_decim: picks the strongest oversampling phase after sync, then decimates and slices to bits
//   clock       : system clock
//   i_reset     : asynchronous active-low reset
//   i_enable    : global enable; low freezes counters/accumulators and suppresses o_valid
//   i_valid     : filter sample valid
//   i_sync      : signal-present flag from the sync detector
//   i_rc_filter : signed raised-cosine filter output
//   o_bit       : sliced symbol (1 when the sample is non-negative)
//   o_valid     : one-cycle pulse qualifying o_bit
//   o_phase     : selected sampling phase
//   o_locked    : high while tracking
module phase_sel_decim import phase_sel_decim_pkg::*; #(
  parameter int S_IN  = 10,
  parameter int OS    = 4,
  parameter int N_ACQ = 64,
  parameter int ACC_W = 16,
  parameter int PH_W  = clog2(OS)
) (
  input  logic                   clock,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_valid,
  input  logic                   i_sync,
  input  logic signed [S_IN-1:0] i_rc_filter,
  output logic                   o_bit,
  output logic                   o_valid,
  output logic [PH_W-1:0]        o_phase,
  output logic                   o_locked
);

  localparam int SC_W = clog2(N_ACQ);

  if (PH_W != clog2(OS)) begin : g_ph_chk
    $error("PH_W must equal log2(OS)");
  end
  if (ACC_W < S_IN + clog2(N_ACQ)) begin : g_acc_chk
    $error("ACC_W too narrow for N_ACQ full-scale samples");
  end

  state_t                   state, state_nx;
  logic [PH_W-1:0]          cnt, best;
  logic [SC_W-1:0]          sym_cnt;
  logic [OS-1:0][ACC_W-1:0] acc;
  logic [S_IN-1:0]          mag;
  logic                     stb, last_ph, sym_end;
  logic                     start, acc_en, slice;

  assign stb     = i_enable & i_valid;
  assign last_ph = cnt == PH_W'(OS - 1);
  assign sym_end = sym_cnt == SC_W'(N_ACQ - 1);
  // unsigned S_IN-bit result holds 2^(S_IN-1) exactly for the most negative input
  assign mag     = i_rc_filter[S_IN-1] ? $unsigned(-i_rc_filter) : $unsigned(i_rc_filter);

  phase_argmax #(.OS(OS), .ACC_W(ACC_W), .PH_W(PH_W)) u_argmax (
    .acc (acc),
    .idx (best)
  );

  always_ff @(posedge clock or negedge i_reset)
    if (!i_reset) state <= IDLE;
    else          state <= state_nx;

  // sync loss takes priority over every forward transition
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (stb & i_sync & last_ph) ? ACQ : IDLE;
      ACQ:     state_nx = !i_sync ? IDLE : (stb & last_ph & sym_end) ? DECIDE : ACQ;
      DECIDE:  state_nx = i_sync ? TRACK : IDLE;
      default: state_nx = i_sync ? TRACK : IDLE;
    endcase
  end

  always_comb begin
    start    = state == IDLE & stb & i_sync & last_ph;
    acc_en   = state == ACQ & stb;
    slice    = state == TRACK & i_sync & stb & cnt == o_phase;
    o_locked = state == TRACK;
  end

  always_ff @(posedge clock or negedge i_reset)
    if (!i_reset) begin
      cnt     <= '0;
      sym_cnt <= '0;
      acc     <= '0;
    end else begin
      if (stb) cnt <= cnt + 1'b1;
      if (start) sym_cnt <= '0;
      else if (acc_en & last_ph) sym_cnt <= sym_cnt + 1'b1;
      if (start) acc <= '0;
      else if (acc_en) acc[cnt] <= acc[cnt] + ACC_W'(mag);
    end

  always_ff @(posedge clock or negedge i_reset)
    if (!i_reset) begin
      o_bit   <= 1'b0;
      o_valid <= 1'b0;
      o_phase <= '0;
    end else begin
      o_valid <= slice;
      if (slice) o_bit <= ~i_rc_filter[S_IN-1];
      if (state == DECIDE & i_sync) o_phase <= best;
    end

endmodule

// File: tb/tb_phase_sel_decim.sv
// tb_phase_sel_decim: randomized scoreboard bench for phase_sel_decim
module tb_phase_sel_decim;

  localparam int OS    = 4;
  localparam int N_ACQ = 64;
  localparam int S_IN  = 10;

  logic                   clock = 1'b0;
  logic                   i_reset = 1'b0;
  logic                   i_enable = 1'b0;
  logic                   i_valid = 1'b0;
  logic                   i_sync = 1'b0;
  logic signed [S_IN-1:0] i_rc_filter = '0;
  logic                   o_bit, o_valid, o_locked;
  logic [1:0]             o_phase;

  typedef struct {
    bit b;
    int c;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0, nvec = 0, nerr = 0, nstb = 0, exp_ph = 0;
  bit   tracking = 1'b0, gap = 1'b0, last_stb = 1'b0;
  int   mags[OS] = '{10, 50, 200, 60};

  phase_sel_decim dut (
    .clock       (clock),
    .i_reset     (i_reset),
    .i_enable    (i_enable),
    .i_valid     (i_valid),
    .i_sync      (i_sync),
    .i_rc_filter (i_rc_filter),
    .o_bit       (o_bit),
    .o_valid     (o_valid),
    .o_phase     (o_phase),
    .o_locked    (o_locked)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string n, input int act, input int req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", n, act, req, cyc);
    end
  endtask

  // kind 0: {10,50,200,60} alternating sign per symbol; 1: +-100; 2: -512 at phase 3 else random;
  // 3: 500 at phase 1 only; 4: tracking pattern +,-,-,+ per symbol
  function automatic logic signed [S_IN-1:0] gen(input int kind, input int s, input int p);
    int v;
    case (kind)
      0:       v = (s % 2 == 1) ? -mags[p] : mags[p];
      1:       v = ($urandom % 2 == 1) ? -100 : 100;
      2:       v = (p == 3) ? -512 : int'($urandom_range(1022)) - 511;
      3:       v = (p == 1) ? 500 : 0;
      default: v = (s % 4 == 1 || s % 4 == 2) ? -mags[p] : mags[p];
    endcase
    return S_IN'(v);
  endfunction

  // one clock; the model counts strobes and predicts a sliced bit when tracking at the chosen phase
  task automatic cycle(input logic signed [S_IN-1:0] x, input bit v, input bit e);
    int ph;
    bit s;
    ph = nstb % OS;
    i_rc_filter = x;
    i_valid = v;
    i_enable = e;
    @(posedge clock);
    #1;
    s = v & e & i_reset;
    last_stb = s;
    if (s) begin
      if (tracking && i_sync && ph == exp_ph) sb.push_back('{x >= 0, cyc});
      nstb++;
    end
  endtask

  task automatic strobe(input logic signed [S_IN-1:0] x);
    bit v, e;
    if (!gap) cycle(x, 1'b1, 1'b1);
    else begin
      for (int k = 0; k < 1000; k++) begin
        v = (cyc % 3 == 0);
        e = ($urandom % 4) != 0;
        if (v && e) begin
          cycle(x, 1'b1, 1'b1);
          return;
        end
        cycle(gen(2, 0, 0), v, e);
      end
      nerr++;
      $display("FAIL strobe_timeout: got no strobe in 1000 cycles, required one");
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $fatal(1, "strobe timeout");
    end
  endtask

  // raise sync and keep strobing until a phase-3 strobe with sync has been seen
  task automatic align();
    int d;
    d = 0;
    i_sync = 1'b1;
    while (d == 0 || nstb % OS != 0) begin
      strobe(gen(2, 0, 0));
      d++;
    end
  endtask

  task automatic acquire(input int kind);
    int en[OS];
    int best;
    logic signed [S_IN-1:0] x;
    tracking = 1'b0;
    for (int p = 0; p < OS; p++) en[p] = 0;
    align();
    for (int s = 0; s < N_ACQ; s++)
      for (int p = 0; p < OS; p++) begin
        x = gen(kind, s, p);
        en[p] += (x < 0) ? -int'(x) : int'(x);
        strobe(x);
      end
    chk("acq_end_unlocked", int'(o_locked), 0);
    best = 0;
    for (int p = 1; p < OS; p++) if (en[p] > en[best]) best = p;
    exp_ph = best;
    if (gap) cycle(gen(2, 0, 0), 1'($urandom), 1'($urandom));
    else cycle(gen(2, 0, 0), 1'b1, 1'b1);
    chk("locked_after_decide", int'(o_locked), 1);
    chk("phase_selected", int'(o_phase), best);
    tracking = 1'b1;
  endtask

  task automatic track(input int nsym);
    for (int i = 0; i < nsym * OS; i++) strobe(gen(4, nstb / OS, nstb % OS));
    cycle(gen(2, 0, 0), 1'b0, 1'b1);
    chk("track_drained", sb.size(), 0);
    chk("track_phase_held", int'(o_phase), exp_ph);
    chk("track_locked", int'(o_locked), 1);
  endtask

  task automatic go_idle();
    i_sync = 1'b0;
    tracking = 1'b0;
    repeat (2) cycle(gen(2, 0, 0), 1'b1, 1'b1);
  endtask

  always @(negedge clock) begin : mon
    exp_t e;
    if (o_valid) begin
      nvec++;
      if (!last_stb) begin
        nerr++;
        $display("FAIL valid_no_strobe: o_valid=1 at cycle %0d, required 0", cyc);
      end else if (sb.size() == 0) begin
        nerr++;
        $display("FAIL unexpected_valid: o_valid=1 bit=%0b at cycle %0d, required no pulse", o_bit, cyc);
      end else begin
        e = sb.pop_front();
        if (o_bit !== e.b || cyc != e.c) begin
          nerr++;
          $display("FAIL bit: got bit %0b at cycle %0d, required bit %0b at cycle %0d", o_bit, cyc, e.b, e.c);
        end
      end
    end
  end

  initial begin
    // reset with random inputs, then 100 strobes without sync
    repeat (5) begin
      i_sync = 1'($urandom);
      cycle(gen(2, 0, 0), 1'($urandom), 1'($urandom));
    end
    chk("rst_bit", int'(o_bit), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_phase", int'(o_phase), 0);
    chk("rst_locked", int'(o_locked), 0);
    i_sync = 1'b0;
    i_reset = 1'b1;
    repeat (100) strobe(gen(2, 0, 0));
    chk("nosync_locked", int'(o_locked), 0);
    chk("nosync_phase", int'(o_phase), 0);

    // weighted phases, then tracking with +,-,-,+ signs
    acquire(0);
    track(8);

    // equal energy ties to phase 0; full-scale negative at phase 3 must not wrap
    go_idle();
    acquire(1);
    track(2);
    go_idle();
    acquire(2);
    track(2);

    // sync loss in TRACK on a strobe at the selected phase
    while (nstb % OS != exp_ph) strobe(gen(4, nstb / OS, nstb % OS));
    i_sync = 1'b0;
    tracking = 1'b0;
    cycle(gen(4, 0, exp_ph), 1'b1, 1'b1);
    chk("drop_locked", int'(o_locked), 0);
    chk("drop_valid", int'(o_valid), 0);
    chk("drop_phase_held", int'(o_phase), exp_ph);
    cycle(gen(2, 0, 0), 1'b1, 1'b1);

    // sync loss mid-ACQ with phase-1-heavy data; the re-acquisition must start clean
    align();
    for (int i = 0; i < 100; i++) strobe(gen(3, i / OS, i % OS));
    go_idle();
    acquire(0);
    track(2);

    // asynchronous reset at ACQ sample 100
    go_idle();
    align();
    for (int i = 0; i < 100; i++) strobe(gen(0, i / OS, i % OS));
    #2 i_reset = 1'b0;
    #1;
    chk("midrst_bit", int'(o_bit), 0);
    chk("midrst_valid", int'(o_valid), 0);
    chk("midrst_phase", int'(o_phase), 0);
    chk("midrst_locked", int'(o_locked), 0);
    nstb = 0;
    tracking = 1'b0;
    sb.delete();
    i_sync = 1'b0;
    repeat (3) cycle(gen(2, 0, 0), 1'b1, 1'b1);
    i_reset = 1'b1;

    // sparse valid and random enable gaps
    gap = 1'b1;
    acquire(0);
    track(8);
    go_idle();
    chk("final_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
